// File: rtl/jtkiwi_gfx_arb.sv
`default_nettype none
// ============================================================================
// Module  : jtkiwi_gfx_arb
// Brief   : Shares one SDRAM graphics slot between the tilemap (scr) and
//           sprite (obj) fetchers. Each requester has a one-word buffer so
//           repeat reads of the last address complete without SDRAM access;
//           misses are arbitrated (blanking-aware, starvation-limited) and
//           issued one at a time on the shared port.
// Rev     : 1.0 - initial release
// ============================================================================
module jtkiwi_gfx_arb #(
  parameter int AW      = 18,
  parameter int DW      = 32,
  parameter int MAXWAIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lhbl,
  input  logic          flush,
  input  logic          scr_cs,
  input  logic [AW-1:0] scr_addr,
  output logic [DW-1:0] scr_data,
  output logic          scr_ok,
  input  logic          obj_cs,
  input  logic [AW-1:0] obj_addr,
  output logic [DW-1:0] obj_data,
  output logic          obj_ok,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok
);

  localparam logic [3:0] c_max_wait = MAXWAIT[3:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_SCR = 2'd1,
    GNT_OBJ = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_scr_valid;
  logic [AW-1:0] r_scr_tag;
  logic [DW-1:0] r_scr_data;
  logic          r_obj_valid;
  logic [AW-1:0] r_obj_tag;
  logic [DW-1:0] r_obj_data;

  logic [3:0]    r_scr_wait;
  logic [3:0]    r_obj_wait;

  logic          r_rom_cs;
  logic [AW-1:0] r_rom_addr;
  logic          r_poison;

  logic          w_scr_hit;
  logic          w_obj_hit;
  logic          w_scr_miss;
  logic          w_obj_miss;
  logic          w_grant_scr;
  logic          w_grant_obj;
  logic          w_store;
  logic          w_store_scr;
  logic          w_store_obj;

  // Buffer lookup is purely combinational so a hit answers in the same cycle
  assign w_scr_hit  = scr_cs & r_scr_valid & (r_scr_tag == scr_addr);
  assign w_obj_hit  = obj_cs & r_obj_valid & (r_obj_tag == obj_addr);
  assign w_scr_miss = scr_cs & ~w_scr_hit;
  assign w_obj_miss = obj_cs & ~w_obj_hit;

  // A returning word is kept only if no flush touched this grant
  assign w_store     = rom_ok & ~flush & ~r_poison;
  assign w_store_scr = w_store & (r_state == GNT_SCR);
  assign w_store_obj = w_store & (r_state == GNT_OBJ);

  assign scr_ok   = w_scr_hit;
  assign obj_ok   = w_obj_hit;
  assign scr_data = r_scr_data;
  assign obj_data = r_obj_data;
  assign rom_cs   = r_rom_cs;
  assign rom_addr = r_rom_addr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and grant decision; starved requester wins before lhbl rule
  always_comb begin
    w_state_nxt = r_state;
    w_grant_scr = 1'b0;
    w_grant_obj = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_scr_miss && w_obj_miss) begin
          if (r_scr_wait == c_max_wait)      w_grant_scr = 1'b1;
          else if (r_obj_wait == c_max_wait) w_grant_obj = 1'b1;
          else if (lhbl)                     w_grant_scr = 1'b1;
          else                               w_grant_obj = 1'b1;
        end else if (w_scr_miss) begin
          w_grant_scr = 1'b1;
        end else if (w_obj_miss) begin
          w_grant_obj = 1'b1;
        end
        if (w_grant_scr)      w_state_nxt = GNT_SCR;
        else if (w_grant_obj) w_state_nxt = GNT_OBJ;
      end
      GNT_SCR, GNT_OBJ: begin
        if (rom_ok) w_state_nxt = GAP;
      end
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shared port: address latched at grant, held until rom_ok, then released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_cs   <= 1'b0;
      r_rom_addr <= '0;
    end else if (w_grant_scr) begin
      r_rom_cs   <= 1'b1;
      r_rom_addr <= scr_addr;
    end else if (w_grant_obj) begin
      r_rom_cs   <= 1'b1;
      r_rom_addr <= obj_addr;
    end else if ((r_state == GNT_SCR || r_state == GNT_OBJ) && rom_ok) begin
      r_rom_cs   <= 1'b0;
    end
  end

  // Poison marks a grant whose data predates a flush and must not be cached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                               r_poison <= 1'b0;
    else if (w_grant_scr || w_grant_obj)                      r_poison <= 1'b0;
    else if ((r_state == GNT_SCR || r_state == GNT_OBJ) && flush) r_poison <= 1'b1;
  end

  // Tilemap buffer: filled from the shared port, invalidated by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scr_valid <= 1'b0;
      r_scr_tag   <= '0;
      r_scr_data  <= '0;
    end else if (w_store_scr) begin
      r_scr_valid <= 1'b1;
      r_scr_tag   <= r_rom_addr;
      r_scr_data  <= rom_data;
    end else if (flush) begin
      r_scr_valid <= 1'b0;
    end
  end

  // Sprite buffer: filled from the shared port, invalidated by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_obj_valid <= 1'b0;
      r_obj_tag   <= '0;
      r_obj_data  <= '0;
    end else if (w_store_obj) begin
      r_obj_valid <= 1'b1;
      r_obj_tag   <= r_rom_addr;
      r_obj_data  <= rom_data;
    end else if (flush) begin
      r_obj_valid <= 1'b0;
    end
  end

  // Starvation counters: count lost cycles while missing, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scr_wait <= 4'd0;
      r_obj_wait <= 4'd0;
    end else begin
      if (!scr_cs || w_grant_scr || r_state == GNT_SCR)
        r_scr_wait <= 4'd0;
      else if (w_scr_miss && r_scr_wait < c_max_wait)
        r_scr_wait <= r_scr_wait + 4'd1;

      if (!obj_cs || w_grant_obj || r_state == GNT_OBJ)
        r_obj_wait <= 4'd0;
      else if (w_obj_miss && r_obj_wait < c_max_wait)
        r_obj_wait <= r_obj_wait + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtkiwi_gfx_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_jtkiwi_gfx_arb
// Brief   : Directed bench for jtkiwi_gfx_arb with an SDRAM responder model
//           and a scoreboard of expected grant addresses.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_jtkiwi_gfx_arb;

  localparam int AW = 18;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lhbl;
  logic          flush;
  logic          scr_cs;
  logic [AW-1:0] scr_addr;
  logic [DW-1:0] scr_data;
  logic          scr_ok;
  logic          obj_cs;
  logic [AW-1:0] obj_addr;
  logic [DW-1:0] obj_data;
  logic          obj_ok;
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          rom_ok;

  logic          rom_ok_auto;
  logic [DW-1:0] rom_data_auto;
  logic          rom_ok_force;
  int            rom_lat;

  int            tests_run = 0;
  int            fails     = 0;
  logic [AW-1:0] exp_q[$];
  int            rise_cnt  = 0;
  int            low_cnt   = 100;
  logic          prev_cs   = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  jtkiwi_gfx_arb #(.AW(AW), .DW(DW), .MAXWAIT(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lhbl     (lhbl),
    .flush    (flush),
    .scr_cs   (scr_cs),
    .scr_addr (scr_addr),
    .scr_data (scr_data),
    .scr_ok   (scr_ok),
    .obj_cs   (obj_cs),
    .obj_addr (obj_addr),
    .obj_data (obj_data),
    .obj_ok   (obj_ok),
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_ok   (rom_ok)
  );

  always #5 clk = ~clk;

  // ROM contents as seen by the bench
  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    if (a == 18'h00100) return 32'hDEADBEEF;
    return {a[13:0], ~a};
  endfunction

  assign rom_ok   = rom_ok_auto | rom_ok_force;
  assign rom_data = rom_ok_force ? 32'h12345678 : rom_data_auto;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // which: 0 scr_ok, 1 obj_ok, 2 rom_ok, 3 rom_cs
  task automatic wait_sig(input string tag, input int which, input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      case (which)
        0:       seen = scr_ok;
        1:       seen = obj_ok;
        2:       seen = rom_ok;
        default: seen = rom_cs;
      endcase
    end
    chk(tag, seen, 1);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // SDRAM responder: one rom_ok per request edge, rom_lat cycles later
  int rsp_st;
  int rsp_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_st        <= 0;
      rsp_cnt       <= 0;
      rom_ok_auto   <= 1'b0;
      rom_data_auto <= '0;
    end else begin
      rom_ok_auto <= 1'b0;
      case (rsp_st)
        0: if (rom_cs) begin rsp_st <= 1; rsp_cnt <= rom_lat - 1; end
        1: if (rsp_cnt == 0) begin
             rom_ok_auto   <= 1'b1;
             rom_data_auto <= mem(rom_addr);
             rsp_st        <= 2;
           end else rsp_cnt <= rsp_cnt - 1;
        default: if (!rom_cs) rsp_st <= 0;
      endcase
    end
  end

  // Grant monitor: scoreboard pop on each request edge, spacing and stability
  always @(negedge clk) begin
    if (rom_cs && !prev_cs) begin
      rise_cnt <= rise_cnt + 1;
      chk("grant_spacing", low_cnt >= 2, 1);
      chk("grant_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("grant_addr", rom_addr, exp_q.pop_front());
    end else if (rom_cs && prev_cs) begin
      chk("rom_addr_stable", rom_addr, prev_addr);
    end
    low_cnt   <= rom_cs ? 0 : low_cnt + 1;
    prev_cs   <= rom_cs;
    prev_addr <= rom_addr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst_n = 1'b1; lhbl = 1'b1; flush = 1'b0; rom_ok_force = 1'b0; rom_lat = 5;
    scr_cs = 1'b0; scr_addr = '0; obj_cs = 1'b0; obj_addr = '0;
    #1 rst_n = 1'b0;

    // Reset state, with a tilemap miss already presented
    scr_cs = 1'b1; scr_addr = 18'h00100;
    exp_q.push_back(18'h00100);
    @(negedge clk);
    chk("rst_rom_cs", rom_cs, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_scr_ok", scr_ok, 0);
    chk("rst_obj_ok", obj_ok, 0);
    chk("rst_scr_data", scr_data, 0);
    chk("rst_obj_data", obj_data, 0);

    // 1: uncontested miss, fill, then hits with no new request
    step(); rst_n = 1'b1;
    @(negedge clk); chk("t1_miss_cycle_rom_cs", rom_cs, 0);
    @(negedge clk); chk("t1_rom_cs", rom_cs, 1);
    chk("t1_rom_addr", rom_addr, 18'h00100);
    wait_sig("t1_rom_ok", 2, 20);
    chk("t1_ok_before_write", scr_ok, 0);
    @(negedge clk);
    chk("t1_scr_ok", scr_ok, 1);
    chk("t1_scr_data", scr_data, 32'hDEADBEEF);
    r = rise_cnt;
    repeat (4) @(negedge clk);
    chk("t1_hit_held", scr_ok, 1);
    chk("t1_no_new_req", rise_cnt, r);
    step(); scr_cs = 1'b0; #1 chk("t1_cs_low_ok", scr_ok, 0);
    step(); scr_cs = 1'b1; #1 chk("t1_rehit_same_cycle", scr_ok, 1);
    chk("t1_no_new_req2", rise_cnt, r);

    // 2: both miss; lhbl=1 serves scr first, lhbl=0 serves obj first
    step(); scr_cs = 1'b0; rom_lat = 2;
    repeat (3) step();
    lhbl = 1'b1; scr_addr = 18'h00300; obj_addr = 18'h00400;
    exp_q.push_back(18'h00300); exp_q.push_back(18'h00400);
    scr_cs = 1'b1; obj_cs = 1'b1;
    wait_sig("t2a_scr_ok", 0, 40);
    wait_sig("t2a_obj_ok", 1, 40);
    chk("t2a_scr_data", scr_data, mem(18'h00300));
    chk("t2a_obj_data", obj_data, mem(18'h00400));
    step(); scr_cs = 1'b0; obj_cs = 1'b0;
    repeat (3) step();
    lhbl = 1'b0; scr_addr = 18'h00310; obj_addr = 18'h00410;
    exp_q.push_back(18'h00410); exp_q.push_back(18'h00310);
    scr_cs = 1'b1; obj_cs = 1'b1;
    wait_sig("t2b_obj_ok", 1, 40);
    wait_sig("t2b_scr_ok", 0, 40);
    chk("t2b_scr_data", scr_data, mem(18'h00310));
    chk("t2b_obj_data", obj_data, mem(18'h00410));

    // 3: scr keeps missing under lhbl=1; obj must be forced in after 8 losses
    step(); scr_cs = 1'b0; obj_cs = 1'b0; rom_lat = 3;
    repeat (3) step();
    lhbl = 1'b1; scr_addr = 18'h00600; obj_addr = 18'h00500;
    exp_q.push_back(18'h00600); exp_q.push_back(18'h00601);
    exp_q.push_back(18'h00500); exp_q.push_back(18'h00602);
    scr_cs = 1'b1; obj_cs = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (scr_ok && obj_ok && scr_addr == 18'h00602) break;
      if (scr_ok && scr_addr != 18'h00602) begin step(); scr_addr = scr_addr + 18'd1; end
    end
    chk("t3_both_served", scr_ok && obj_ok, 1);
    chk("t3_obj_data", obj_data, mem(18'h00500));
    chk("t3_scr_data", scr_data, mem(18'h00602));

    // 4: obj changes address mid-grant; access completes under the old tag
    step(); scr_cs = 1'b0; obj_cs = 1'b0;
    repeat (3) step();
    obj_addr = 18'h00200; exp_q.push_back(18'h00200); obj_cs = 1'b1;
    wait_sig("t4_rom_cs", 3, 20);
    step(); obj_addr = 18'h00204;
    @(negedge clk); chk("t4_rom_addr_held", rom_addr, 18'h00200);
    wait_sig("t4_rom_ok", 2, 20);
    chk("t4_obj_ok_rom_ok_cycle", obj_ok, 0);
    @(negedge clk); chk("t4_obj_ok_after_write", obj_ok, 0);
    step(); obj_addr = 18'h00200;
    #1 chk("t4_tag_is_old_addr", obj_ok, 1);
    chk("t4_old_data", obj_data, mem(18'h00200));
    step(); obj_addr = 18'h00204; exp_q.push_back(18'h00204);
    wait_sig("t4_new_obj_ok", 1, 40);
    chk("t4_new_data", obj_data, mem(18'h00204));

    // 5: flush during a tilemap grant poisons the fill and drops obj's hit
    rom_lat = 5;
    @(negedge clk); chk("t5_obj_hit_before", obj_ok, 1);
    step(); scr_addr = 18'h00700; exp_q.push_back(18'h00700); scr_cs = 1'b1;
    wait_sig("t5_rom_cs", 3, 20);
    step(); flush = 1'b1;
    step(); flush = 1'b0;
    @(negedge clk); chk("t5_obj_hit_lost", obj_ok, 0);
    step(); obj_cs = 1'b0;
    wait_sig("t5_rom_ok", 2, 20);
    @(negedge clk);
    chk("t5_rom_cs_dropped", rom_cs, 0);
    chk("t5_scr_not_filled", scr_ok, 0);
    step(); scr_cs = 1'b0;
    repeat (2) step();

    // 6: async reset during an obj grant, then stray rom_ok is ignored
    rom_lat = 6; obj_addr = 18'h00800; exp_q.push_back(18'h00800); obj_cs = 1'b1;
    wait_sig("t6_rom_cs", 3, 20);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("t6_rom_cs_async", rom_cs, 0);
    chk("t6_obj_ok", obj_ok, 0);
    chk("t6_scr_ok", scr_ok, 0);
    obj_cs = 1'b0; obj_addr = '0; lhbl = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    r = rise_cnt;
    step(); rom_ok_force = 1'b1;
    step(); rom_ok_force = 1'b0;
    step(); rom_ok_force = 1'b1;
    step(); rom_ok_force = 1'b0;
    step();
    chk("t6_no_req_after_stray_ok", rise_cnt, r);
    scr_addr = '0; obj_addr = '0;
    exp_q.push_back(18'h00000); exp_q.push_back(18'h00000);
    scr_cs = 1'b1; obj_cs = 1'b1;
    #1;
    chk("t6_scr_not_written", scr_ok, 0);
    chk("t6_obj_not_written", obj_ok, 0);
    wait_sig("t6_obj_ok", 1, 60);
    chk("t6_obj_data", obj_data, mem(18'h00000));
    chk("t6_scr_ok", scr_ok, 1);
    chk("t6_scr_data", scr_data, mem(18'h00000));

    step(); scr_cs = 1'b0; obj_cs = 1'b0;
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire
